// File: rtl/ext_pkg.sv
// Shared encodings and default widths for the immediate extender slice.
package ext_pkg;

    localparam int DEFAULT_IN_W  = 16;
    localparam int DEFAULT_OUT_W = 32;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'd0,
        EXT_SIGN  = 2'd1,
        EXT_UPPER = 2'd2,
        EXT_SHIFT = 2'd3
    } ext_op_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero, sign, upper-load and sign-then-shift.
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int IN_W      = DEFAULT_IN_W,
    parameter int OUT_W     = DEFAULT_OUT_W,
    parameter int SHIFT_AMT = 2
) (
    input  ext_op_t            extOp,
    input  logic [IN_W-1:0]    immediate,
    output logic [OUT_W-1:0]   result
);

    logic [OUT_W-1:0] zeroExt;
    logic [OUT_W-1:0] signExt;
    logic [OUT_W-1:0] upperExt;

    assign zeroExt  = {{(OUT_W-IN_W){1'b0}}, immediate};
    assign signExt  = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
    assign upperExt = {immediate, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        result = '0;
        unique case (extOp)
            EXT_ZERO:  result = zeroExt;
            EXT_SIGN:  result = signExt;
            EXT_UPPER: result = upperExt;
            EXT_SHIFT: result = signExt << SHIFT_AMT;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer and flush.
// Define EXT_STATS_EN to add saturating transfer/stall counters.
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W      = DEFAULT_IN_W,
    parameter int OUT_W     = DEFAULT_OUT_W,
    parameter int SHIFT_AMT = 2,
    parameter int CNT_W     = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic [1:0]         ExtOp,
    input  logic [IN_W-1:0]    Immediate,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [OUT_W-1:0]   ImExtend
`ifdef EXT_STATS_EN
    ,
    output logic [CNT_W-1:0]   XferCnt,
    output logic [CNT_W-1:0]   StallCnt
`endif
);

    logic [OUT_W-1:0] extD;
    logic             mainV, skidV;
    logic [OUT_W-1:0] mainD, skidD;
    logic             mainVN, skidVN;
    logic [OUT_W-1:0] mainDN, skidDN;
    logic             inHs, outHs;

    imm_ext_core #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .SHIFT_AMT (SHIFT_AMT)
    ) uCore (
        .extOp     (ext_op_t'(ExtOp)),
        .immediate (Immediate),
        .result    (extD)
    );

    assign inHs     = InValid && InReady;
    assign outHs    = mainV && OutReady;
    assign OutValid = mainV;
    assign ImExtend = mainD;

    // skidV is only ever set while mainV is set, so main empties last.
    always_comb begin
        mainVN = mainV;
        mainDN = mainD;
        skidVN = skidV;
        skidDN = skidD;
        if (outHs) begin
            if (skidV) begin
                mainDN = skidD;
                skidVN = 1'b0;
            end else if (inHs) begin
                mainDN = extD;
            end else begin
                mainVN = 1'b0;
            end
        end else if (!mainV) begin
            if (inHs) begin
                mainVN = 1'b1;
                mainDN = extD;
            end
        end else if (inHs) begin
            skidVN = 1'b1;
            skidDN = extD;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mainV   <= 1'b0;
            skidV   <= 1'b0;
            mainD   <= '0;
            skidD   <= '0;
            InReady <= 1'b0;
        end else if (Flush) begin
            mainV   <= 1'b0;
            skidV   <= 1'b0;
            InReady <= 1'b1;
        end else begin
            mainV   <= mainVN;
            skidV   <= skidVN;
            mainD   <= mainDN;
            skidD   <= skidDN;
            InReady <= !skidVN;
        end
    end

`ifdef EXT_STATS_EN
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            XferCnt  <= '0;
            StallCnt <= '0;
        end else begin
            if (outHs && (XferCnt != '1))
                XferCnt <= XferCnt + 1'b1;
            if (mainV && !OutReady && (StallCnt != '1))
                StallCnt <= StallCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (optionally with EXT_STATS_EN).
module tb_imm_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
`ifdef EXT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic             CLK = 1'b0;
    logic             Reset;
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [1:0]       ExtOp;
    logic [IN_W-1:0]  Immediate;
    logic             OutValid;
    logic             OutReady;
    logic [OUT_W-1:0] ImExtend;
`ifdef EXT_STATS_EN
    logic [CNT_W-1:0] XferCnt;
    logic [CNT_W-1:0] StallCnt;
`endif

    int nAsserts = 0;
    int nFails   = 0;

    imm_ext_pipe #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .SHIFT_AMT (2),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Flush     (Flush),
        .InValid   (InValid),
        .InReady   (InReady),
        .ExtOp     (ExtOp),
        .Immediate (Immediate),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .ImExtend  (ImExtend)
`ifdef EXT_STATS_EN
        ,
        .XferCnt   (XferCnt),
        .StallCnt  (StallCnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        assert (got === exp) else begin
            nFails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] expB2b;

    initial begin
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; ExtOp = 2'd0;
        Immediate = '0; OutReady = 1'b0;
        #3;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_imextend", ImExtend, 32'd0);
        check("rst_inready", 32'(InReady), 32'd0);
        tick(); tick();
        check("rst_held_inready", 32'(InReady), 32'd0);
        Reset = 1'b1;
        check("rst_deassert_inready", 32'(InReady), 32'd0);
        tick();
        check("rst_rise_inready", 32'(InReady), 32'd1);

        // Extension modes, each 1 cycle after its handshake
        OutReady = 1'b1; InValid = 1'b1; Immediate = 16'h8001;
        ExtOp = 2'd0; tick();
        check("mode0_valid", 32'(OutValid), 32'd1);
        check("mode0_data", ImExtend, 32'h00008001);
        ExtOp = 2'd1; tick();
        check("mode1_data", ImExtend, 32'hFFFF8001);
        ExtOp = 2'd2; tick();
        check("mode2_data", ImExtend, 32'h80010000);
        ExtOp = 2'd3; tick();
        check("mode3_data", ImExtend, 32'hFFFE0004);
        check("mode3_valid", 32'(OutValid), 32'd1);
        InValid = 1'b0; tick();
        check("modes_drain", 32'(OutValid), 32'd0);

        // Back-pressure: 1..4 with OutReady low
        OutReady = 1'b0; InValid = 1'b1; ExtOp = 2'd0;
        Immediate = 16'h0001; tick();
        check("bp_acc1_inready", 32'(InReady), 32'd1);
        Immediate = 16'h0002; tick();
        check("bp_acc2_inready", 32'(InReady), 32'd0);
        check("bp_hold1", ImExtend, 32'h1);
        check("bp_valid", 32'(OutValid), 32'd1);
        Immediate = 16'h0003; tick();
        check("bp_full_hold", ImExtend, 32'h1);
        check("bp_full_inready", 32'(InReady), 32'd0);
        OutReady = 1'b1; tick();
        check("bp_out2", ImExtend, 32'h2);
        check("bp_reopen", 32'(InReady), 32'd1);
        tick();
        check("bp_out3", ImExtend, 32'h3);
        Immediate = 16'h0004; tick();
        check("bp_out4", ImExtend, 32'h4);
        check("bp_out4_valid", 32'(OutValid), 32'd1);
        InValid = 1'b0; tick();
        check("bp_drain", 32'(OutValid), 32'd0);

        // Back-to-back sign extension across the sign boundary
        InValid = 1'b1; ExtOp = 2'd1;
        for (int i = 0; i < 8; i++) begin
            Immediate = 16'h7FFC + 16'(i);
            expB2b = (i < 4) ? 32'h00007FFC + 32'(i) : 32'hFFFF8000 + 32'(i - 4);
            tick();
            check("b2b_valid", 32'(OutValid), 32'd1);
            check("b2b_data", ImExtend, expB2b);
            check("b2b_inready", 32'(InReady), 32'd1);
        end
        InValid = 1'b0; tick();
        check("b2b_drain", 32'(OutValid), 32'd0);

        // Flush with both entries full and InValid high
        OutReady = 1'b0; InValid = 1'b1; ExtOp = 2'd0;
        Immediate = 16'hAAAA; tick();
        Immediate = 16'h5555; tick();
        check("fl_full", 32'(InReady), 32'd0);
        Immediate = 16'h1234; Flush = 1'b1; tick();
        check("fl_outvalid", 32'(OutValid), 32'd0);
        check("fl_inready", 32'(InReady), 32'd1);
        // Flush beats a real in-handshake with one entry held
        Flush = 1'b0; Immediate = 16'h1111; tick();
        check("fl2_load", ImExtend, 32'h1111);
        Immediate = 16'h2222; Flush = 1'b1; tick();
        check("fl2_outvalid", 32'(OutValid), 32'd0);
        check("fl2_inready", 32'(InReady), 32'd1);
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1; tick();
        check("fl_nothing_left", 32'(OutValid), 32'd0);
        tick();
        check("fl_nothing_left2", 32'(OutValid), 32'd0);
        InValid = 1'b1; Immediate = 16'h0042; tick();
        check("fl_next_data", ImExtend, 32'h42);
        check("fl_next_valid", 32'(OutValid), 32'd1);
        InValid = 1'b0; tick();
        check("fl_next_drain", 32'(OutValid), 32'd0);

        // Asynchronous reset mid-stream
        OutReady = 1'b0; InValid = 1'b1; Immediate = 16'h0007; tick();
        check("mr_loaded", ImExtend, 32'h7);
        Immediate = 16'h0008;
        #2 Reset = 1'b0;
        #1;
        check("mr_outvalid", 32'(OutValid), 32'd0);
        check("mr_imextend", ImExtend, 32'd0);
        check("mr_inready", 32'(InReady), 32'd0);
        tick();
        Reset = 1'b1; InValid = 1'b0;
        tick();
        check("mr_inready_rise", 32'(InReady), 32'd1);
        check("mr_outvalid_after", 32'(OutValid), 32'd0);

`ifdef EXT_STATS_EN
        check("st_xfer_reset", 32'(XferCnt), 32'd0);
        check("st_stall_reset", 32'(StallCnt), 32'd0);
        OutReady = 1'b1; InValid = 1'b1; Immediate = 16'h0009;
        for (int i = 0; i < 22; i++) tick();
        check("st_xfer_sat", 32'(XferCnt), 32'hF);
        check("st_stall_zero", 32'(StallCnt), 32'd0);
        OutReady = 1'b0; InValid = 1'b0;
        tick(); tick(); tick();
        check("st_stall3", 32'(StallCnt), 32'd3);
        OutReady = 1'b1; Flush = 1'b1; tick();
        Flush = 1'b0;
        check("st_flush_stall", 32'(StallCnt), 32'd3);
        check("st_flush_xfer", 32'(XferCnt), 32'hF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate extender for the pipelined datapath; sits between the decode-stage immediate field and the execute-stage operand mux.
- Four modes: zero-extend, sign-extend, upper-load (immediate placed in the high bits) and sign-extend-then-shift (branch offset).
- Decoupled by a valid/ready handshake through a 2-entry skid buffer, giving full throughput with a registered InReady.
- Supports pipeline flush.

Parameters:
- IN_W, 16, immediate input width; 1 <= IN_W < OUT_W.
- OUT_W, 32, extended output width.
- SHIFT_AMT, 2, left shift applied in mode 3; 0 <= SHIFT_AMT < OUT_W.
- CNT_W, 32, statistics counter width (used only with EXT_STATS_EN).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous discard of all buffered entries.
- InValid  input  1  Immediate/ExtOp valid.
- InReady  output  1  buffer can accept this cycle.
- ExtOp  input  2  mode: 0 zero, 1 sign, 2 upper, 3 sign+shift.
- Immediate  input  IN_W  raw immediate field.
- OutValid  output  1  ImExtend valid.
- OutReady  input  1  consumer accepts this cycle.
- ImExtend  output  OUT_W  extended result.
- XferCnt  output  CNT_W  only with EXT_STATS_EN.
- StallCnt  output  CNT_W  only with EXT_STATS_EN.

Behaviour:
- Extension function, combinational on input; the result is captured, not the raw input:
  - mode 0: {(OUT_W-IN_W) zeros, Immediate}.
  - mode 1: {(OUT_W-IN_W) copies of Immediate[IN_W-1], Immediate}.
  - mode 2: {Immediate, (OUT_W-IN_W) zeros}.
  - mode 3: (mode-1 result) << SHIFT_AMT, truncated to OUT_W; vacated LSBs are 0.
- Storage:
  - Main register (main_v, main_d) drives OutValid and ImExtend.
  - Skid register (skid_v, skid_d) holds one extra entry.
- Handshakes:
  - In-handshake = InValid && InReady; out-handshake = OutValid && OutReady.
  - InReady is a register equal to !skid_v of the next state.
- Latency: 1 cycle from in-handshake to OutValid when empty. Throughput: 1 per cycle while OutReady stays high.
- Per-edge update, no flush:
  - Out-handshake with skid_v=1: main <- skid, skid_v <- 0.
  - Out-handshake with skid_v=0: main <- new entry if in-handshake, else main_v <- 0.
  - No out-handshake with main_v=0: main <- new entry if in-handshake.
  - No out-handshake with main_v=1 and in-handshake: skid <- new entry, skid_v <- 1, so InReady drops the next cycle.
- Simultaneous in- and out-handshake with skid empty: pass-through, main replaced, occupancy unchanged.
- Full (main_v=skid_v=1): InReady=0; InValid is ignored; Immediate may change freely.
- Flush: at the edge, main_v, skid_v <- 0 and InReady <- 1. Flush beats any same-cycle in-handshake, which is dropped. The data registers keep their stale values.
- Reset values: OutValid=0, ImExtend=0, InReady=0, skid_v=0. InReady rises at the first CLK edge after Reset deasserts.
- Reset mid-operation discards all entries immediately.
- Protocol rules:
  - While OutValid=1 && OutReady=0, ImExtend is held stable.
  - OutValid never drops without an out-handshake or a Flush.

Optional Feature:
- Macro: EXT_STATS_EN.
- When defined:
  - XferCnt increments on each out-handshake.
  - StallCnt increments on each cycle with OutValid && !OutReady.
  - Both saturate at all-ones, reset to 0, and are not cleared by Flush.
- When undefined: neither port nor the counters exist, and the behaviour is otherwise identical.

Decomposition:
- Package ext_pkg holds:
  - ExtOp encodings EXT_ZERO=2'd0, EXT_SIGN=2'd1, EXT_UPPER=2'd2, EXT_SHIFT=2'd3.
  - Default widths IN_W/OUT_W and the ext_op_t typedef.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W, SHIFT_AMT; ExtOp, Immediate -> result), instantiated on the input side.
- The skid/handshake logic stays in imm_ext_pipe.

Test Plan:
- Modes, IN_W=16, OUT_W=32, Immediate=16'h8001, OutReady=1:
  - ExtOp 0 -> 32'h00008001.
  - ExtOp 1 -> 32'hFFFF8001.
  - ExtOp 2 -> 32'h80010000.
  - ExtOp 3 -> 32'hFFFE0004.
  - Each appears 1 cycle after its in-handshake.
- Back-pressure: stream 16'h0001..16'h0004 with OutReady=0 -> InReady falls after 2 accepts, ImExtend holds 0x1. Raise OutReady -> outputs 1,2,3,4 in order, none lost or duplicated.
- Back-to-back: 8 consecutive sign-extend inputs with OutReady=1 -> 8 consecutive OutValid cycles, InReady constantly 1.
- Flush with both entries full, same cycle as InValid=1 -> next cycle OutValid=0, InReady=1; the flushed and the dropped entries never appear.
- Reset: assert Reset mid-stream -> OutValid=0, ImExtend=0, InReady=0 immediately. After deassert, InReady=1 after one edge.
- EXT_STATS_EN with CNT_W=4: 20 transfers -> XferCnt saturates at 4'hF. 3 stalled cycles -> StallCnt=3. A Flush leaves both counters unchanged.
